cic_decimator: RTL and testbench
================================

# cic_decimator

Parametrised N-th order CIC decimation filter for the echip65 sigma-delta readout chain. It takes the 1-bit modulator stream at the modulator clock. It produces signed, gain-normalised decimated samples with a one-cycle valid strobe. Order, maximum decimation, input coding and a runtime-selectable power-of-two decimation ratio are configurable, and a transient-suppression window hides unsettled outputs.

## Interface
One clock; reset is synchronous and active-high.

**Parameters**
- `ORDER`, default 3: number of integrator and comb stages (1..5).
- `MAX_DECIM_LOG2`, default 8: log2 of the largest decimation factor.
- `BIPOLAR`, default 1: input coding. 1 maps `in=1` to +1 and `in=0` to -1. 0 maps `in=1` to +1 and `in=0` to 0.
- `NUMBITS`, default `ORDER*MAX_DECIM_LOG2+2`: internal and output width, two's complement.
- `SEL_W`, default `$clog2(MAX_DECIM_LOG2+1)`: width of `decim_sel`.

**Ports**
- `clk`, input, 1: modulator clock.
- `reset`, input, 1: synchronous, active-high.
- `in`, input, 1: modulator bit.
- `enable`, input, 1: gates integrators and the decimation counter.
- `decim_sel`, input, `SEL_W`: decimation factor D = 2^`decim_sel`. A value of 0 or greater than `MAX_DECIM_LOG2` is treated as `MAX_DECIM_LOG2`.
- `out`, output, `NUMBITS`: signed normalised sample.
- `out_valid`, output, 1: one-cycle strobe qualifying `out`.

## Operation
- **Input coding:** `in` is sign-extended to `NUMBITS` as +1, -1 or 0 per `BIPOLAR`.
- **Integrators:** on every cycle with `enable=1`, `acc1 <= acc1 + x` and `acc_k <= acc_k + acc_{k-1}`, all registered. Modular wrap is intentional and never flagged.
- **Decimation counter:** counts 0..D-1 while `enable=1` and holds while `enable=0`.
  - A tick is a cycle where `counter==D-1` and `enable=1`.
  - At a tick the counter wraps to 0.
  - `decim_sel` is sampled only at a tick. It takes effect from the next frame.
- **Comb pipeline:** one stage per cycle, driven by a valid shift register of depth `ORDER`. It runs regardless of `enable`.
  - At the tick, stage 0 captures the current `acc_ORDER`.
  - Stage k computes `c_k <= c_{k-1} - c_{k-1}_d` and `c_{k-1}_d <= c_{k-1}`, one cycle after stage k-1.
- **Normalisation:** `out = c_ORDER <<< ORDER*(MAX_DECIM_LOG2 - log2 D)`. Full scale is ±2^(`ORDER*MAX_DECIM_LOG2`) at every D.
- **Warm-up:**
  - A counter suppresses `out_valid` for the first `ORDER` comb results after reset or after an applied change of D.
  - `out` still updates during suppression.
  - The warm-up counter saturates at `ORDER`.
  - It restarts when a change of D is applied; a sampled value equal to the current D is not a change.

## Timing
- **Reset values:** all accumulators, comb registers and delays, counter, warm-up count, `out` and `out_valid` are 0. The effective D resets to 2^`MAX_DECIM_LOG2`.
- **Latency:** a tick at cycle t gives `out`/`out_valid` at t+`ORDER`+1.
- **Output rate:** with `enable` held high, `out_valid` pulses exactly every D cycles.
- **Minimum D:** D=2 is legal. The valid shift register carries overlapping samples, so no sample is dropped even when `ORDER`+1 > D.
- **`enable` low:** integrators and counter freeze. In-flight comb samples still complete, and the output spacing stretches by the number of low cycles.
- **Reset mid-frame:** reset wins over all events. The pipeline is flushed, and no `out_valid` appears until the warm-up completes again.
- **Tick and rate change in the same cycle:** the frame ending at that tick still uses the old D. The new D takes effect for the following frame, and warm-up restarts.

## Structure
- **`cic_pkg`:**
  - `cic_coding_e` (`UNIPOLAR`, `BIPOLAR`).
  - Function `cic_width(order, max_log2)`.
  - Function `clamp_sel(sel, max_log2)`.
- **Sub-module `cic_comb_stage`:** a single registered differentiator with delay register and valid in/out. It is instantiated `ORDER` times in a generate loop.
- **Top level:** integrators, counter, warm-up logic and the normalising shifter stay in the top.

## Test plan
All scenarios use `ORDER=3`, `MAX_DECIM_LOG2=8`.

1. **Reset:** assert `reset` for 5 cycles with random `in` → `out=0` and `out_valid=0` throughout, and for 256*3 cycles after release there is no `out_valid`.
2. **Bipolar constant 1, `decim_sel=8`:** first `out_valid` follows the 4th tick, at cycle 4*256-1+4 after reset release; `out=0x1000000` (2^24). Constant 0 gives `out=-2^24`.
3. **Bipolar alternating 1010…, `decim_sel=8`:** every valid `out=0`, spaced exactly 256 cycles apart.
4. **Bipolar constant 1, change `decim_sel` 8→4 mid-frame:** the current 256-cycle frame completes. The next 3 comb results are suppressed. Then `out=2^24` with `out_valid` every 16 cycles.
5. **Unipolar constant 1, `decim_sel=1` (D=2):** `out_valid` every 2 cycles with `out=2^24` after warm-up, and no dropped strobes.
6. **Bipolar constant 1, `decim_sel=8`, `enable` low for 100 cycles mid-frame:** that `out_valid` interval is 356 cycles, `out` stays 2^24, and the next interval is back to 256.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and elaboration helpers for the CIC decimator slice.
package cic_pkg;

  typedef enum logic {
    UNIPOLAR = 1'b0,
    BIPOLAR  = 1'b1
  } cic_coding_e;

  // Word growth of an N-stage CIC at D = 2^max_log2, plus sign and headroom.
  function automatic int cic_width(input int order, input int max_log2);
    return order * max_log2 + 32'sd2;
  endfunction

  // Zero or out-of-range selectors fall back to the largest decimation.
  function automatic int clamp_sel(input int sel, input int max_log2);
    int r;
    if ((sel == 32'sd0) || (sel > max_log2)) begin
      r = max_log2;
    end else begin
      r = sel;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator; data advances only with a valid sample,
// the valid bit advances every cycle.
module cic_comb_stage #(
  parameter int W = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] din,
  input  logic                vin,
  output logic signed [W-1:0] dout,
  output logic                vout
);

  logic signed [W-1:0] dly_r;

  // Difference against the previous valid sample, then remember this one.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout  <= '0;
      dly_r <= '0;
      vout  <= 1'b0;
    end else begin
      vout <= vin;
      if (vin) begin
        dout  <= din - dly_r;
        dly_r <= din;
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// N-th order CIC decimator for a 1-bit sigma-delta stream with runtime
// power-of-two ratio, gain normalisation and post-change output suppression.
module cic_decimator #(
  parameter int ORDER          = 3,
  parameter int MAX_DECIM_LOG2 = 8,
  parameter int BIPOLAR        = 1,
  parameter int NUMBITS        = cic_pkg::cic_width(ORDER, MAX_DECIM_LOG2),
  parameter int SEL_W          = $clog2(MAX_DECIM_LOG2 + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in,
  input  logic                      enable,
  input  logic [SEL_W-1:0]          decim_sel,
  output logic signed [NUMBITS-1:0] out,
  output logic                      out_valid
);

  import cic_pkg::*;

  localparam int CNT_W  = MAX_DECIM_LOG2;
  localparam int WARM_W = $clog2(ORDER + 1);
  localparam int SH_W   = $clog2(ORDER * MAX_DECIM_LOG2 + 1);
  localparam cic_coding_e CODING_C = (BIPOLAR != 0) ? cic_pkg::BIPOLAR : cic_pkg::UNIPOLAR;
  localparam logic signed [NUMBITS-1:0] ONE_C       = NUMBITS'(1);
  localparam logic signed [NUMBITS-1:0] MINUS_ONE_C = {NUMBITS{1'b1}};
  localparam logic [WARM_W-1:0]         WARM_MAX_C  = WARM_W'(ORDER);

  logic signed [NUMBITS-1:0] x_s;
  logic signed [NUMBITS-1:0] acc_r [ORDER];
  logic [CNT_W-1:0]          cnt_r;
  logic [CNT_W:0]            term_s;
  logic [SEL_W-1:0]          dlog_r;
  logic [SEL_W-1:0]          sel_new_s;
  logic                      tick_s;
  logic                      chg_s;
  logic [SEL_W-1:0]          dlog_pipe_r [ORDER];
  logic                      restart_pipe_r [ORDER];
  logic signed [NUMBITS-1:0] comb_d_s [ORDER+1];
  logic                      comb_v_s [ORDER+1];
  logic [SH_W-1:0]           shamt_s;
  logic [WARM_W-1:0]         warm_r;

  // Map the modulator bit onto a signed sample.
  always_comb begin
    x_s = '0;
    case (CODING_C)
      cic_pkg::BIPOLAR:  x_s = in ? ONE_C : MINUS_ONE_C;
      cic_pkg::UNIPOLAR: x_s = in ? ONE_C : '0;
      default:           x_s = '0;
    endcase
  end

  // Frame terminal count, rate selection and change detection at the tick.
  always_comb begin
    term_s    = ({{CNT_W{1'b0}}, 1'b1} << dlog_r) - {{CNT_W{1'b0}}, 1'b1};
    tick_s    = enable & (cnt_r == term_s[CNT_W-1:0]);
    sel_new_s = SEL_W'(clamp_sel(int'(decim_sel), MAX_DECIM_LOG2));
    chg_s     = tick_s & (sel_new_s != dlog_r);
    shamt_s   = SH_W'(ORDER * (MAX_DECIM_LOG2 - int'(dlog_pipe_r[ORDER-1])));
  end

  // Integrator cascade; modular wrap is harmless because the combs undo it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) begin
        acc_r[k] <= '0;
      end
    end else if (enable) begin
      acc_r[0] <= acc_r[0] + x_s;
      for (int k = 1; k < ORDER; k++) begin
        acc_r[k] <= acc_r[k] + acc_r[k-1];
      end
    end
  end

  // Decimation counter; a new ratio is adopted only when a frame closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      dlog_r <= SEL_W'(MAX_DECIM_LOG2);
    end else if (tick_s) begin
      cnt_r  <= '0;
      dlog_r <= sel_new_s;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Ratio and restart tags travel alongside each sample through the combs,
  // so overlapping samples at small D keep their own normalisation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) begin
        dlog_pipe_r[k]    <= '0;
        restart_pipe_r[k] <= 1'b0;
      end
    end else begin
      dlog_pipe_r[0]    <= dlog_r;
      restart_pipe_r[0] <= chg_s;
      for (int k = 1; k < ORDER; k++) begin
        dlog_pipe_r[k]    <= dlog_pipe_r[k-1];
        restart_pipe_r[k] <= restart_pipe_r[k-1];
      end
    end
  end

  assign comb_d_s[0] = acc_r[ORDER-1];
  assign comb_v_s[0] = tick_s;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .W (NUMBITS)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .din   (comb_d_s[k]),
      .vin   (comb_v_s[k]),
      .dout  (comb_d_s[k+1]),
      .vout  (comb_v_s[k+1])
    );
  end

  // Normalise and qualify results. The sample closing the old-rate frame is
  // still clean; the warm-up restarts right after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      warm_r    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (comb_v_s[ORDER]) begin
        out <= comb_d_s[ORDER] <<< shamt_s;
        if (restart_pipe_r[ORDER-1]) begin
          out_valid <= (warm_r == WARM_MAX_C);
          warm_r    <= '0;
        end else if (warm_r == WARM_MAX_C) begin
          out_valid <= 1'b1;
        end else begin
          warm_r <= warm_r + WARM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator (ORDER=3, MAX_DECIM_LOG2=8), bipolar and
// unipolar instances sharing one stimulus.
module tb_cic_decimator;

  localparam int     NB = 26;
  localparam longint FS = 64'sd16777216;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_bit;
  logic                 enable;
  logic [3:0]           decim_sel;
  logic signed [NB-1:0] out_b;
  logic signed [NB-1:0] out_u;
  logic                 valid_b;
  logic                 valid_u;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = 1;
  int lo_start = -1;
  int lo_end = -1;
  int     vb_cyc[$];
  longint vb_val[$];
  int     vu_cyc[$];
  longint vu_val[$];

  always #5 clk = ~clk;

  cic_decimator #(.ORDER(3), .MAX_DECIM_LOG2(8), .BIPOLAR(1)) u_dut (
    .clk(clk), .reset(reset), .in(in_bit), .enable(enable),
    .decim_sel(decim_sel), .out(out_b), .out_valid(valid_b)
  );

  cic_decimator #(.ORDER(3), .MAX_DECIM_LOG2(8), .BIPOLAR(0)) u_uni (
    .clk(clk), .reset(reset), .in(in_bit), .enable(enable),
    .decim_sel(decim_sel), .out(out_u), .out_valid(valid_u)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint b_cyc(input int i);
    return (i < vb_cyc.size()) ? longint'(vb_cyc[i]) : -64'sd1;
  endfunction
  function automatic longint b_val(input int i);
    return (i < vb_val.size()) ? vb_val[i] : -64'sd1;
  endfunction

  task automatic do_reset(input int sel, input int md);
    reset = 1'b1;
    enable = 1'b1;
    decim_sel = 4'(sel);
    mode = md;
    for (int i = 0; i < 5; i++) begin
      in_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("reset_out", longint'(out_b), 64'sd0);
      check_eq("reset_valid", longint'(valid_b), 64'sd0);
    end
    reset = 1'b0;
    cyc = 0;
    lo_start = -1;
    lo_end = -1;
    vb_cyc.delete(); vb_val.delete();
    vu_cyc.delete(); vu_val.delete();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) begin
      case (mode)
        0:       in_bit = 1'b0;
        1:       in_bit = 1'b1;
        default: in_bit = ~cyc[0];
      endcase
      enable = !((cyc >= lo_start) && (cyc < lo_end));
      @(posedge clk); #1;
      cyc++;
      if (valid_b) begin vb_cyc.push_back(cyc); vb_val.push_back(longint'(out_b)); end
      if (valid_u) begin vu_cyc.push_back(cyc); vu_val.push_back(longint'(out_u)); end
    end
  endtask

  initial begin
    int exp_cyc[10];

    // Reset, warm-up silence, then first valid of constant +1
    do_reset(8, 1);
    run_to(768);
    check_eq("warmup_silent", longint'(vb_cyc.size()), 64'sd0);
    run_to(1100);
    check_eq("c1_count", longint'(vb_cyc.size()), 64'sd1);
    check_eq("c1_first_cyc", b_cyc(0), 64'sd1027);
    check_eq("c1_value", b_val(0), FS);

    // Constant 0 in bipolar coding is full-scale negative
    do_reset(8, 0);
    run_to(1100);
    check_eq("c0_count", longint'(vb_cyc.size()), 64'sd1);
    check_eq("c0_first_cyc", b_cyc(0), 64'sd1027);
    check_eq("c0_value", b_val(0), -FS);

    // Alternating input averages to zero
    do_reset(8, 2);
    run_to(1800);
    check_eq("alt_count", longint'(vb_cyc.size()), 64'sd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("alt_cyc", b_cyc(i), longint'(1027 + 256 * i));
      check_eq("alt_value", b_val(i), 64'sd0);
    end

    // Rate change 256 -> 16 mid-frame
    do_reset(8, 1);
    run_to(1400);
    decim_sel = 4'd4;
    run_to(1700);
    exp_cyc[0] = 1027; exp_cyc[1] = 1283; exp_cyc[2] = 1539;
    for (int i = 3; i < 10; i++) exp_cyc[i] = 1603 + 16 * (i - 3);
    check_eq("chg_count", longint'(vb_cyc.size()), 64'sd10);
    for (int i = 0; i < 10; i++) begin
      check_eq("chg_cyc", b_cyc(i), longint'(exp_cyc[i]));
      check_eq("chg_value", b_val(i), FS);
    end

    // Unipolar at D=2: overlapping samples, one strobe every 2 cycles
    do_reset(1, 1);
    run_to(307);
    check_eq("d2_count", longint'(vu_cyc.size()), 64'sd21);
    for (int i = 0; i < 21; i++) begin
      check_eq("d2_cyc", (i < vu_cyc.size()) ? longint'(vu_cyc[i]) : -64'sd1, longint'(267 + 2 * i));
      check_eq("d2_value", (i < vu_val.size()) ? vu_val[i] : -64'sd1, FS);
    end

    // Enable low for 100 cycles stretches one interval
    do_reset(8, 1);
    lo_start = 1300;
    lo_end = 1400;
    run_to(1900);
    check_eq("en_count", longint'(vb_cyc.size()), 64'sd4);
    check_eq("en_cyc1", b_cyc(1), 64'sd1283);
    check_eq("en_gap_stretched", b_cyc(2) - b_cyc(1), 64'sd356);
    check_eq("en_gap_normal", b_cyc(3) - b_cyc(2), 64'sd256);
    for (int i = 0; i < 4; i++) check_eq("en_value", b_val(i), FS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
